// File: rtl/c5g_housekeeping_i2c_bus_scheduler.sv
// Round-robin owner of the housekeeping I2C master and device-select mux: grant, settle, start, hold until done/timeout.
// Grant 1 cycle after req; mst_start SETTLE_CYCLES later; requesters wait (req held) while another owns the bus.
`timescale 1ns/1ps
module c5g_housekeeping_i2c_bus_scheduler #(
  parameter int NREQ           = 4,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] req_dev,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done_pulse,
  output logic [NREQ-1:0]   timeout_pulse,
  output logic [1:0]        dev_sel,
  output logic              mst_start,
  input  logic              mst_done,
  output logic              busy
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [15:0]   TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    LAST_RESET   = 2'(NREQ - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_START,
    ST_WAIT,
    ST_RELEASE
  } state_t;

  state_t          state;
  logic [1:0]      last_owner;
  logic [SW-1:0]   settle_cnt;
  logic [15:0]     timer;

  logic            win_found;
  logic [1:0]      win_idx;
  logic [NREQ-1:0] win_oh;
  logic [1:0]      win_dev;

  // Offset k walks the rotation from last_owner+1; the first offset with a live request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_oh    = '0;
    win_dev   = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!win_found && req[j] && (j == (int'(last_owner) + 1 + k) % NREQ)) begin
          win_found  = 1'b1;
          win_idx    = 2'(j);
          win_oh[j]  = 1'b1;
          win_dev    = req_dev[2*j +: 2];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      grant         <= '0;
      done_pulse    <= '0;
      timeout_pulse <= '0;
      dev_sel       <= 2'b00;
      mst_start     <= 1'b0;
      busy          <= 1'b0;
      last_owner    <= LAST_RESET;
      settle_cnt    <= '0;
      timer         <= '0;
    end else begin
      mst_start     <= 1'b0;
      done_pulse    <= '0;
      timeout_pulse <= '0;
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            state      <= ST_SELECT;
            grant      <= win_oh;
            dev_sel    <= win_dev;
            last_owner <= win_idx;
            settle_cnt <= '0;
            busy       <= 1'b1;
          end
        end
        ST_SELECT: begin
          if (settle_cnt == SETTLE_LAST) begin
            state     <= ST_START;
            mst_start <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        ST_START: begin
          state <= ST_WAIT;
          timer <= '0;
        end
        ST_WAIT: begin
          // Completion is checked first so a done arriving on the expiry cycle still counts as done.
          if (mst_done) begin
            state      <= ST_RELEASE;
            grant      <= '0;
            done_pulse <= grant;
          end else if (timer == TIMEOUT_LAST) begin
            state         <= ST_RELEASE;
            grant         <= '0;
            timeout_pulse <= grant;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        ST_RELEASE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/c5g_housekeeping_i2c_bus_scheduler.md
# c5g_housekeeping_i2c_bus_scheduler

Round-robin scheduler that shares the single housekeeping I2C master and the 2-bit I2C device-select mux among up to four requesters. It grants one requester at a time and drives the device-select lines with that requester's target. It waits for the mux to settle, issues a one-cycle start to the I2C master, then holds ownership until the master reports done or a timeout expires. It sits between the housekeeping requesters (Nios PIO path, monitor FSMs) and the I2C master core.

## Interface
Parameters:
- NREQ, 4, number of requesters (1..4)
- SETTLE_CYCLES, 8, clk cycles dev_sel is held stable before mst_start (>=1)
- TIMEOUT_CYCLES, 65535, max clk cycles from mst_start to mst_done (>=2, <=65535)

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- req  in  NREQ  per-requester request level; held until that requester's done_pulse or timeout_pulse
- req_dev  in  2*NREQ  target device per requester; requester i uses bits [2i+1:2i]
- grant  out  NREQ  one-hot (or zero) ownership indicator
- done_pulse  out  NREQ  one-cycle pulse to the owner on normal completion
- timeout_pulse  out  NREQ  one-cycle pulse to the owner on timeout
- dev_sel  out  2  device-select to I2C mux
- mst_start  out  1  one-cycle start strobe to I2C master
- mst_done  in  1  completion strobe from I2C master (level or pulse; sampled only in WAIT)
- busy  out  1  high in every state except IDLE

## Operation
- FSM states and transitions:
  - IDLE -> SELECT when any req bit is set.
  - SELECT -> START after SETTLE_CYCLES cycles.
  - START -> WAIT after exactly one cycle.
  - WAIT -> RELEASE on mst_done, or when the timeout counter reaches TIMEOUT_CYCLES.
  - RELEASE -> IDLE after exactly one cycle.
- Arbitration (IDLE only):
  - Round-robin search starting at (last_owner+1) mod NREQ.
  - After reset, last_owner = NREQ-1, so requester 0 has first priority.
  - Winner is registered into grant and owner; its req_dev is latched into dev_sel.
  - req_dev changes after latch are ignored.
- grant stays set during SELECT, START and WAIT. grant clears on entry to RELEASE, which is also the cycle the owner's done_pulse or timeout_pulse fires.
- dev_sel keeps its last value in IDLE and RELEASE. It changes only when a new grant is made.
- Owner dropping req mid-transaction: not an abort. The transaction runs to completion and the pulse still fires.
- Non-owner req changes: no effect until the next IDLE arbitration.
- mst_done in IDLE, SELECT, START or RELEASE is ignored.
- Timeout counter:
  - 16 bits wide; cleared in START and incremented each WAIT cycle.
  - On expiry, timeout_pulse fires instead of done_pulse.
  - If mst_done and expiry occur in the same cycle, done wins.
- Requesters with index >= NREQ do not exist. Unused req_dev bits are ignored.

## Timing
- Reset values: grant=0, done_pulse=0, timeout_pulse=0, dev_sel=2'b00, mst_start=0, busy=0, FSM=IDLE, counters=0, last_owner=NREQ-1.
- Reset mid-transaction forces all of the above immediately (asynchronous). No pulse is emitted.
- With req first seen high at cycle 0 in IDLE:
  - Cycle 1: grant, dev_sel and busy are valid.
  - Cycles 1..SETTLE_CYCLES: SELECT.
  - Cycle SETTLE_CYCLES+1: mst_start=1, for that cycle only.
  - From cycle SETTLE_CYCLES+2: WAIT.
- mst_done sampled high at WAIT cycle N: at N+1, RELEASE with done_pulse and grant=0; at N+2, IDLE with busy=0; at N+3, the earliest next grant.
- Back-to-back grants are therefore separated by at least 2 idle-of-grant cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Single requester (NREQ=4, SETTLE_CYCLES=8): req[2]=1, req_dev[5:4]=2'b10 at cycle 0.
  - Expect grant=4'b0100 and dev_sel=2'b10 at cycle 1, and mst_start only at cycle 9.
  - Drive mst_done at cycle 20: expect done_pulse[2] and grant=0 at cycle 21, busy=0 at cycle 22.
- Contention: req=4'b1011 held continuously, each transaction completed. Expect grant order 0,1,3,0,1,3. Then req[2] rises: expect it is served after the current owner, before 0 repeats if next in rotation.
- Timeout (TIMEOUT_CYCLES=16): never assert mst_done. Expect timeout_pulse[owner] exactly 17 cycles after mst_start, and no done_pulse. Drive mst_done and expiry in the same cycle: expect done_pulse only.
- Owner drops req in WAIT: the transaction continues. mst_done still yields done_pulse. A second requester is granted afterwards.
- Spurious mst_done during SELECT: ignored, no early release. mst_start still issues on schedule.
- Reset asserted in WAIT: all outputs go to reset values with no pulse. After release, requester 0 has priority.
